// File: rtl/bitwise_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_pipe_if
// Brief    : Handshake bundle for bitwise_pipe. Optional flag signals are
//            present when BITWISE_PIPE_FLAGS_EN is defined.
// Revision : 1.0
// ============================================================================
interface bitwise_pipe_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [2:0]           in_op;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CNT_WIDTH-1:0] xfer_count;
`ifdef BITWISE_PIPE_FLAGS_EN
    logic                 out_zr;
    logic                 out_ng;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, xfer_count, out_zr, out_ng
    );
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, xfer_count, out_zr, out_ng
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, xfer_count
    );
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, xfer_count
    );
`endif
endinterface
`default_nettype wire

// File: rtl/bitwise_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_pipe
// Brief    : Eight-op bitwise unit feeding a 2-entry valid/ready output
//            buffer with a transfer counter. Macro BITWISE_PIPE_FLAGS_EN
//            adds per-entry zero/negative flags.
// Revision : 1.0
// ============================================================================
module bitwise_pipe #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    bitwise_pipe_if.slave  bus
);

    localparam logic [2:0] c_OP_NOT  = 3'b000;
    localparam logic [2:0] c_OP_AND  = 3'b001;
    localparam logic [2:0] c_OP_OR   = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_NAND = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_XNOR = 3'b110;

`ifdef BITWISE_PIPE_FLAGS_EN
    localparam int FLAG_W = 2;
`else
    localparam int FLAG_W = 0;
`endif
    localparam int ENTRY_W = WIDTH + FLAG_W;

    localparam logic [1:0]           c_FULL    = 2'd2;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     w_result;
    logic [ENTRY_W-1:0]   w_entry;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_in_ready;
    logic                 w_out_valid;

    logic [ENTRY_W-1:0]   r_head;
    logic [ENTRY_W-1:0]   r_tail;
    logic [1:0]           r_count;
    logic [CNT_WIDTH-1:0] r_xfer;

    always_comb begin
        w_result = bus.in_a;
        case (bus.in_op)
            c_OP_NOT:  w_result = ~bus.in_a;
            c_OP_AND:  w_result = bus.in_a & bus.in_b;
            c_OP_OR:   w_result = bus.in_a | bus.in_b;
            c_OP_XOR:  w_result = bus.in_a ^ bus.in_b;
            c_OP_NAND: w_result = ~(bus.in_a & bus.in_b);
            c_OP_NOR:  w_result = ~(bus.in_a | bus.in_b);
            c_OP_XNOR: w_result = ~(bus.in_a ^ bus.in_b);
            default:   w_result = bus.in_a;
        endcase
    end

`ifdef BITWISE_PIPE_FLAGS_EN
    // Flags are captured with the data so they always track the buffer head.
    assign w_entry = {w_result[WIDTH-1], (w_result == '0), w_result};
`else
    assign w_entry = w_result;
`endif

    // in_ready depends only on occupancy, never on out_ready.
    assign w_in_ready  = (r_count < c_FULL);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
            r_xfer  <= '0;
        end else begin
            // Push and pop together can only happen at occupancy 1.
            if (w_push && w_pop) begin
                r_head <= w_entry;
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head <= w_entry;
                end else begin
                    r_tail <= w_entry;
                end
                r_count <= r_count + 2'd1;
            end else if (w_pop) begin
                r_head  <= r_tail;
                r_count <= r_count - 2'd1;
            end

            if (w_pop) begin
                r_xfer <= r_xfer + c_CNT_ONE;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = r_head[WIDTH-1:0];
    assign bus.xfer_count = r_xfer;
`ifdef BITWISE_PIPE_FLAGS_EN
    assign bus.out_zr     = r_head[WIDTH];
    assign bus.out_ng     = r_head[WIDTH+1];
`endif

endmodule
`default_nettype wire
